mult_add_taps: RTL and testbench

// N-tap unsigned multiply-add with a valid-qualified pipeline and a fixed-latency output.

---
 rtl/mult_add_taps_pkg.sv | 31 +++
 rtl/mult_add_taps_pipe_delay.sv | 33 +++
 rtl/mult_add_taps.sv | 206 ++++++++++++++++++++
 tb/tb_mult_add_taps.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_add_taps_pkg.sv
// Shared opcodes and helpers for the N-tap multiply-add.
// Imported by the datapath top and its delay-line sub-module.
package mult_add_taps_pkg;

    typedef logic [1:0] op_t;

    // Input-stage opcodes: how the a-taps update on a valid sample.
    localparam op_t INOP_NOP  = 2'b00;
    localparam op_t INOP_LOAD = 2'b01;
    localparam op_t INOP_FIR  = 2'b10;
    localparam op_t INOP_HOLD = 2'b11;

    // Calculation opcodes: what the sum stage produces.
    localparam op_t CALCOP_SUM    = 2'b00;
    localparam op_t CALCOP_BYPASS = 2'b01;
    localparam op_t CALCOP_ZERO   = 2'b10;
    localparam op_t CALCOP_RSVD   = 2'b11;

    // Ceiling log2 for elaboration-time widths; 1 -> 0, 2 -> 1, 5 -> 3.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_add_taps_pipe_delay.sv
// Fixed-depth register delay line, cleared by reset.
// Aligns sideband bits and provides the optional output stages.
module pipe_delay
#(
    parameter int W     = 1,
    parameter int DEPTH = 1
)
(
    input  logic         CLK_i,
    input  logic         nRST_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift register; stage 0 takes the input every cycle.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mult_add_taps.sv
// N-tap unsigned multiply-add, four fixed stages plus optional
// output delay; load/FIR taps, bypass, rounding, saturation.
module mult_add_taps
    import mult_add_taps_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int A_W       = 8,
    parameter int B_W       = 8,
    parameter int OUT_W     = 8,
    parameter int POST_REGS = 0,
    parameter int ROUND     = 0,
    localparam int SEL_W    = clog2(N_TAPS)
)
(
    input  logic                  CLK_i,
    input  logic                  nRST_i,
    input  logic                  valid_i,
    input  logic [1:0]            inopcode_i,
    input  logic [1:0]            calcopcode_i,
    input  logic [SEL_W-1:0]      bypass_sel_i,
    input  logic [N_TAPS*A_W-1:0] data_a_i,
    input  logic [N_TAPS*B_W-1:0] data_b_i,
    output logic                  valid_o,
    output logic [OUT_W-1:0]      result_data_o,
    output logic                  overflow_o
);

    localparam int PW  = A_W + B_W;
    localparam int SW  = PW + clog2(N_TAPS);
    localparam int SH  = PW - OUT_W;
    localparam int RSH = (OUT_W < PW) ? (PW - OUT_W - 1) : 0;
    localparam logic [SW:0] RND_C =
        ((ROUND != 0) && (OUT_W < PW)) ? ((SW+1)'(1) << RSH) : '0;

    // ---------------- S1: tap registers ----------------
    logic [A_W-1:0]   a_q [N_TAPS];
    logic [A_W-1:0]   a_d [N_TAPS];
    logic [B_W-1:0]   b_q [N_TAPS];
    logic             v1_q;
    op_t              calc1_q;
    logic [SEL_W-1:0] sel1_q;

    // Next a-tap values: parallel load, FIR shift, or hold.
    always_comb begin
        a_d = a_q;
        if (valid_i) begin
            unique case (1'b1)
                (inopcode_i == INOP_LOAD): begin
                    for (int k = 0; k < N_TAPS; k++) begin
                        a_d[k] = data_a_i[k*A_W +: A_W];
                    end
                end
                (inopcode_i == INOP_FIR): begin
                    a_d[0] = data_a_i[0 +: A_W];
                    for (int k = 1; k < N_TAPS; k++) begin
                        a_d[k] = a_q[k-1];
                    end
                end
                (inopcode_i == INOP_NOP),
                (inopcode_i == INOP_HOLD): begin
                    a_d = a_q;
                end
            endcase
        end
    end

    // Tap and control capture, qualified by valid_i.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            for (int k = 0; k < N_TAPS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            v1_q    <= 1'b0;
            calc1_q <= CALCOP_SUM;
            sel1_q  <= '0;
        end else begin
            a_q  <= a_d;
            v1_q <= valid_i;
            if (valid_i) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    b_q[k] <= data_b_i[k*B_W +: B_W];
                end
                calc1_q <= calcopcode_i;
                sel1_q  <= bypass_sel_i;
            end
        end
    end

    // ---------------- S2: products ----------------
    logic [N_TAPS*PW-1:0] prod_w;
    logic [N_TAPS*PW-1:0] p_q;
    logic [SEL_W-1:0]     byp_idx;
    logic [A_W-1:0]       byp_q;
    logic                 v2;
    op_t                  calc2;

    for (genvar k = 0; k < N_TAPS; k++) begin : g_mul
        assign prod_w[k*PW +: PW] = PW'(a_q[k]) * PW'(b_q[k]);
    end

    // Out-of-range bypass selects fall back to tap 0.
    assign byp_idx = (int'(sel1_q) < N_TAPS) ? sel1_q : '0;

    // Register products and the bypass tap for the sum stage.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            p_q   <= '0;
            byp_q <= '0;
        end else begin
            p_q   <= prod_w;
            byp_q <= a_q[byp_idx];
        end
    end

    pipe_delay #(.W(3), .DEPTH(1)) u_side2 (
        .CLK_i  (CLK_i),
        .nRST_i (nRST_i),
        .d_i    ({v1_q, calc1_q}),
        .q_o    ({v2, calc2})
    );

    // ---------------- S3: sum / bypass / zero ----------------
    logic [SW-1:0] tree_w;
    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;
    logic          v3;
    op_t           calc3;

    // Adder tree over all products, then the calc-mode override.
    always_comb begin
        tree_w = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            tree_w = tree_w + SW'(p_q[k*PW +: PW]);
        end
        sum_d = tree_w;
        unique case (1'b1)
            (calc2 == CALCOP_BYPASS): sum_d = SW'({byp_q, {B_W{1'b0}}});
            (calc2 == CALCOP_ZERO):   sum_d = '0;
            (calc2 == CALCOP_SUM),
            (calc2 == CALCOP_RSVD):   sum_d = tree_w;
        endcase
    end

    // Register the selected sum.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    pipe_delay #(.W(3), .DEPTH(1)) u_side3 (
        .CLK_i  (CLK_i),
        .nRST_i (nRST_i),
        .d_i    ({v2, calc2}),
        .q_o    ({v3, calc3})
    );

    // ---------------- S4: round, scale, saturate ----------------
    logic [SW:0]      rsum_w;
    logic [SW:0]      shf_w;
    logic             sat_w;
    logic [OUT_W-1:0] res_q;
    logic             ovf_q;
    logic             v4_q;

    // Anything left above the OUT_W window after the shift means
    // the rounded sum reached 2^PW.
    assign rsum_w = {1'b0, sum_q} + RND_C;
    assign shf_w  = rsum_w >> SH;
    assign sat_w  = |shf_w[SW:OUT_W];

    // Output register; result and flag hold between valid samples.
    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            v4_q  <= 1'b0;
        end else begin
            v4_q <= v3;
            if (v3) begin
                res_q <= sat_w ? '1 : shf_w[OUT_W-1:0];
                ovf_q <= sat_w && (calc3 != CALCOP_BYPASS);
            end
        end
    end

    // ---------------- optional output delay ----------------
    if (POST_REGS > 0) begin : g_post
        logic [OUT_W+1:0] post_w;

        pipe_delay #(.W(OUT_W+2), .DEPTH(POST_REGS)) u_post (
            .CLK_i  (CLK_i),
            .nRST_i (nRST_i),
            .d_i    ({v4_q, ovf_q, res_q}),
            .q_o    (post_w)
        );

        assign {valid_o, overflow_o, result_data_o} = post_w;
    end else begin : g_nopost
        assign {valid_o, overflow_o, result_data_o} = {v4_q, ovf_q, res_q};
    end

endmodule

// File: tb/tb_mult_add_taps.sv
// Bench for mult_add_taps: three configurations driven in lockstep,
// checked every cycle against a per-sample arithmetic model.
module tb_mult_add_taps;

    logic        CLK_i = 1'b0;
    logic        nRST_i;
    logic        valid;
    logic [1:0]  inop;
    logic [1:0]  calc;
    logic [2:0]  sel;
    logic [7:0]  a_tap [8];
    logic [7:0]  b_tap [8];
    logic [47:0] da6;
    logic [47:0] db6;
    logic [2:0]  vo;
    logic [2:0]  oo;
    logic [23:0] ro;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Per-DUT configuration: taps, rounding, latency, select mask.
    int nd  [3] = '{4, 4, 6};
    int rd  [3] = '{0, 1, 0};
    int lat [3] = '{4, 6, 4};
    int smk [3] = '{3, 3, 7};

    int mA [3][8];
    bit ev [3][4096];
    int er [3][4096];
    bit eo [3][4096];
    int hr [3];
    bit ho [3];

    always #5 CLK_i = ~CLK_i;

    always_comb begin
        da6 = '0;
        db6 = '0;
        for (int k = 0; k < 6; k++) begin
            da6[k*8 +: 8] = a_tap[k];
            db6[k*8 +: 8] = b_tap[k];
        end
    end

    mult_add_taps #(
        .N_TAPS(4), .A_W(8), .B_W(8), .OUT_W(8),
        .POST_REGS(0), .ROUND(0)
    ) u_a (
        .CLK_i(CLK_i), .nRST_i(nRST_i), .valid_i(valid),
        .inopcode_i(inop), .calcopcode_i(calc),
        .bypass_sel_i(sel[1:0]),
        .data_a_i(da6[31:0]), .data_b_i(db6[31:0]),
        .valid_o(vo[0]), .result_data_o(ro[7:0]),
        .overflow_o(oo[0])
    );

    mult_add_taps #(
        .N_TAPS(4), .A_W(8), .B_W(8), .OUT_W(8),
        .POST_REGS(2), .ROUND(1)
    ) u_b (
        .CLK_i(CLK_i), .nRST_i(nRST_i), .valid_i(valid),
        .inopcode_i(inop), .calcopcode_i(calc),
        .bypass_sel_i(sel[1:0]),
        .data_a_i(da6[31:0]), .data_b_i(db6[31:0]),
        .valid_o(vo[1]), .result_data_o(ro[15:8]),
        .overflow_o(oo[1])
    );

    mult_add_taps #(
        .N_TAPS(6), .A_W(8), .B_W(8), .OUT_W(8),
        .POST_REGS(0), .ROUND(0)
    ) u_c (
        .CLK_i(CLK_i), .nRST_i(nRST_i), .valid_i(valid),
        .inopcode_i(inop), .calcopcode_i(calc),
        .bypass_sel_i(sel),
        .data_a_i(da6), .data_b_i(db6),
        .valid_o(vo[2]), .result_data_o(ro[23:16]),
        .overflow_o(oo[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result of one sample from the taps as they stand after update.
    function automatic void predict(input int d, output int r,
                                    output bit o);
        int s;
        int sv;
        s  = 0;
        sv = int'(sel) & smk[d];
        if (calc == 2'b10) begin
            s = 0;
        end else if (calc == 2'b01) begin
            s = mA[d][(sv < nd[d]) ? sv : 0] * 256;
        end else begin
            for (int k = 0; k < nd[d]; k++) begin
                s += mA[d][k] * int'(b_tap[k]);
            end
        end
        if (rd[d] != 0) s += 128;
        if (s >= 65536) begin
            r = 255;
            o = (calc != 2'b01);
        end else begin
            r = s / 256;
            o = 1'b0;
        end
    endfunction

    task automatic capture();
        int r;
        bit o;
        if (!nRST_i || !valid) return;
        for (int d = 0; d < 3; d++) begin
            if (inop == 2'b01) begin
                for (int k = 0; k < nd[d]; k++) mA[d][k] = int'(a_tap[k]);
            end else if (inop == 2'b10) begin
                for (int k = nd[d] - 1; k > 0; k--) mA[d][k] = mA[d][k-1];
                mA[d][0] = int'(a_tap[0]);
            end
            predict(d, r, o);
            ev[d][cyc + lat[d] - 1] = 1'b1;
            er[d][cyc + lat[d] - 1] = r;
            eo[d][cyc + lat[d] - 1] = o;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            if (ev[d][cyc]) begin
                hr[d] = er[d][cyc];
                ho[d] = eo[d][cyc];
            end
            chk($sformatf("d%0d_vld@%0d", d, cyc), 32'(vo[d]), 32'(ev[d][cyc]));
            chk($sformatf("d%0d_res@%0d", d, cyc), 32'(ro[d*8 +: 8]), hr[d]);
            chk($sformatf("d%0d_ovf@%0d", d, cyc), 32'(oo[d]), 32'(ho[d]));
        end
    endtask

    task automatic step();
        @(posedge CLK_i);
        cyc++;
        capture();
        @(negedge CLK_i);
        check_all();
    endtask

    task automatic send();
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic reset_pulse();
        nRST_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            for (int i = cyc + 1; i < cyc + 12; i++) ev[d][i] = 1'b0;
            for (int k = 0; k < 8; k++) mA[d][k] = 0;
            hr[d] = 0;
            ho[d] = 1'b0;
        end
        step();
        nRST_i = 1'b1;
    endtask

    task automatic fill(input logic [7:0] av, input logic [7:0] bv);
        for (int k = 0; k < 8; k++) begin
            a_tap[k] = av;
            b_tap[k] = bv;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        nRST_i = 1'b0;
        valid  = 1'b0;
        inop   = 2'b00;
        calc   = 2'b00;
        sel    = 3'd0;
        fill(8'h00, 8'h00);
        for (int d = 0; d < 3; d++) begin
            hr[d] = 0;
            ho[d] = 1'b0;
            for (int k = 0; k < 8; k++) mA[d][k] = 0;
        end
        repeat (2) @(negedge CLK_i);
        chk("rst_vld", 32'(vo), 0);
        chk("rst_res", 32'(ro), 0);
        chk("rst_ovf", 32'(oo), 0);
        nRST_i = 1'b1;
        step();

        // Normal sum and latency of both output depths.
        inop = 2'b01;
        calc = 2'b00;
        fill(8'h80, 8'h40);
        send();
        step();
        step();
        chk("t1_early", 32'(vo[0]), 0);
        step();
        chk("t1_vld", 32'(vo[0]), 1);
        chk("t1_res", 32'(ro[7:0]), 32'h80);
        chk("t1_ovf", 32'(oo[0]), 0);
        chk("t1_res6", 32'(ro[23:16]), 32'hC0);
        chk("lat6_c3", 32'(vo[1]), 0);
        step();
        chk("t1_pulse", 32'(vo[0]), 0);
        chk("t1_hold", 32'(ro[7:0]), 32'h80);
        chk("lat6_c4", 32'(vo[1]), 0);
        step();
        chk("lat6_c5", 32'(vo[1]), 1);
        chk("t1_res_b", 32'(ro[15:8]), 32'h80);
        step();

        // Saturation.
        fill(8'hFF, 8'hFF);
        send();
        repeat (3) step();
        chk("t2_res", 32'(ro[7:0]), 32'hFF);
        chk("t2_ovf", 32'(oo[0]), 1);
        chk("t2_ovf6", 32'(oo[2]), 1);
        repeat (2) step();
        chk("t2_ovf_b", 32'(oo[1]), 1);

        // Rounding versus truncation.
        fill(8'h00, 8'h00);
        a_tap[0] = 8'h03;
        b_tap[0] = 8'h80;
        send();
        repeat (3) step();
        chk("t5_trunc", 32'(ro[7:0]), 32'h01);
        repeat (2) step();
        chk("t5_round", 32'(ro[15:8]), 32'h02);

        // Bypass, in range and out of range.
        for (int k = 0; k < 8; k++) a_tap[k] = 8'($urandom_range(0, 255));
        a_tap[2] = 8'h5A;
        calc = 2'b01;
        sel  = 3'd2;
        send();
        a_tap[0] = 8'h33;
        sel = 3'd7;
        send();
        repeat (2) step();
        chk("t4_byp", 32'(ro[7:0]), 32'h5A);
        chk("t4_byp_ovf", 32'(oo[0]), 0);
        chk("t4_byp6", 32'(ro[23:16]), 32'h5A);
        step();
        chk("t4_sel7", 32'(ro[23:16]), 32'h33);
        repeat (4) step();

        // FIR shift with gaps that must not shift.
        calc = 2'b00;
        inop = 2'b10;
        fill(8'h00, 8'h00);
        b_tap[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            a_tap[0] = 8'(2 * (i + 1));
            for (int k = 1; k < 8; k++) a_tap[k] = 8'($urandom_range(0, 255));
            send();
            a_tap[0] = 8'hEE;
            step();
        end
        repeat (2) step();
        chk("t3_fir", 32'(ro[7:0]), 32'h01);
        chk("t3_fir6", 32'(ro[23:16]), 32'h01);
        repeat (4) step();

        // Reset with three samples in flight.
        inop = 2'b01;
        fill(8'h77, 8'h99);
        valid = 1'b1;
        repeat (3) step();
        valid = 1'b0;
        reset_pulse();
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("t6_novld%0d", i), 32'(vo), 0);
        end
        chk("t6_res", 32'(ro), 0);
        chk("t6_ovf", 32'(oo), 0);

        // Randomized traffic with one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 9) < 7);
            inop  = 2'($urandom_range(0, 3));
            calc  = 2'($urandom_range(0, 3));
            sel   = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a_tap[k] = 8'hF0 | 8'($urandom_range(0, 15));
                    b_tap[k] = 8'hF0 | 8'($urandom_range(0, 15));
                end else begin
                    a_tap[k] = 8'($urandom_range(0, 255));
                    b_tap[k] = 8'($urandom_range(0, 255));
                end
            end
            if (i == 200) reset_pulse();
            else step();
        end
        valid = 1'b0;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
